// File: rtl/axi5_pkg.sv
// Shared AXI5 encodings and small helpers used by the bus interface and the
// SRAM responder.
package axi5_pkg;

  typedef logic [2:0] AXSize_t;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10
  } AXBurst_t;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    SLVERR = 2'b10
  } XRESP_t;

  // WRAP bursts are only legal for 2, 4, 8 or 16 beats.
  function automatic logic wrap_len_ok(input logic [7:0] len);
    return (len == 8'd1) || (len == 8'd3) || (len == 8'd7) || (len == 8'd15);
  endfunction

endpackage

// File: rtl/axi5_if.sv
// AXI5 bus bundle: five channels, each a packed payload plus valid/ready.
interface axi5
  import axi5_pkg::*;
#(
  parameter int alen = 32,
  parameter int xlen = 32,
  parameter int ilen = 2
) ();

  typedef struct packed {
    logic [ilen-1:0] id;
    logic [alen-1:0] addr;
    logic [7:0]      len;
    AXSize_t         size;
    AXBurst_t        burst;
  } ax_t;

  typedef struct packed {
    logic [xlen-1:0]   data;
    logic [xlen/8-1:0] strb;
    logic              last;
  } w_t;

  typedef struct packed {
    logic [ilen-1:0] id;
    XRESP_t          resp;
  } b_t;

  typedef struct packed {
    logic [ilen-1:0] id;
    logic [xlen-1:0] data;
    XRESP_t          resp;
    logic            last;
  } r_t;

  ax_t  aw;
  logic aw_valid, aw_ready;
  w_t   w;
  logic w_valid, w_ready;
  b_t   b;
  logic b_valid, b_ready;
  ax_t  ar;
  logic ar_valid, ar_ready;
  r_t   r;
  logic r_valid, r_ready;

  modport master (
    output aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready,
    input  aw_ready, w_ready, b, b_valid, ar_ready, r, r_valid
  );

  modport slave (
    input  aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready,
    output aw_ready, w_ready, b, b_valid, ar_ready, r, r_valid
  );

endinterface

// File: rtl/axi5_burst_addr.sv
// Combinational beat address for one burst beat, reduced to a word index,
// plus the flag saying the beat must be answered with SLVERR.
module axi5_burst_addr
  import axi5_pkg::*;
#(
  parameter int alen  = 32,
  parameter int xlen  = 32,
  parameter int depth = 256
) (
  input  logic [alen-1:0]            base,
  input  AXSize_t                    size,
  input  AXBurst_t                   burst,
  input  logic [7:0]                 len,
  input  logic [7:0]                 beat,
  output logic [$clog2(depth)-1:0]   idx,
  output logic                       bad
);

  localparam int          OFF  = $clog2(xlen/8);
  localparam int          IW   = $clog2(depth);
  localparam logic [63:0] SPAN = 64'(depth) * 64'(xlen/8);

  logic [alen-1:0] addr, lin, wrap_mask, size_mask;

  // Address per burst type, then the legality checks on that address.
  always_comb begin
    lin       = base + (alen'(beat) << size);
    wrap_mask = ((alen'(len) + alen'(1)) << size) - alen'(1);
    size_mask = (alen'(1) << size) - alen'(1);
    case (burst)
      FIXED:   addr = base;
      WRAP:    addr = (base & ~wrap_mask) | (lin & wrap_mask);
      default: addr = lin;
    endcase
    bad = 1'b0;
    if (64'(addr) >= SPAN) bad = 1'b1;
    if (size > 3'(OFF)) bad = 1'b1;
    if (burst == WRAP && (!wrap_len_ok(len) || (base & size_mask) != '0)) bad = 1'b1;
    idx = addr[OFF +: IW];
  end

endmodule

// File: rtl/axi5_sram_slave.sv
// AXI5 responder backed by a flop-array memory. Independent write and read
// FSMs, one outstanding burst each.
module axi5_sram_slave
  import axi5_pkg::*;
#(
  parameter int alen  = 32,
  parameter int xlen  = 32,
  parameter int ilen  = 2,
  parameter int depth = 256
) (
  input  logic clk,
  input  logic rst_n,
  axi5.slave   bus
);

  localparam int NB = xlen / 8;
  localparam int IW = $clog2(depth);

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic {R_IDLE, R_DATA} r_state_t;

  typedef struct packed {
    logic [ilen-1:0] id;
    logic [alen-1:0] addr;
    logic [7:0]      len;
    AXSize_t         size;
    AXBurst_t        burst;
  } ax_t;

  typedef struct packed {
    logic [ilen-1:0] id;
    XRESP_t          resp;
  } b_t;

  typedef struct packed {
    logic [ilen-1:0] id;
    logic [xlen-1:0] data;
    XRESP_t          resp;
    logic            last;
  } r_t;

  logic [xlen-1:0] mem_q [depth];

  logic     rdy_en_d, rdy_en_q;
  w_state_t w_state_d, w_state_q;
  ax_t      aw_d, aw_q;
  logic [7:0] w_cnt_d, w_cnt_q;
  logic     w_err_d, w_err_q;
  r_state_t r_state_d, r_state_q;
  ax_t      ar_d, ar_q;
  logic [7:0] r_cnt_d, r_cnt_q;
  r_t       r_d, r_q;

  logic          mem_we;
  logic [IW-1:0] w_idx, rd_idx;
  logic          w_bad, rd_bad;
  b_t            b_o;
  logic [alen-1:0] rd_addr;
  AXSize_t       rd_size;
  AXBurst_t      rd_burst;
  logic [7:0]    rd_len, rd_beat;
  logic [xlen-1:0] rd_data;

  assign rdy_en_d = 1'b1;

  // Readies stay low until the cycle after reset is seen released.
  always_ff @(posedge clk) begin
    if (!rst_n) rdy_en_q <= 1'b0;
    else        rdy_en_q <= rdy_en_d;
  end

  axi5_burst_addr #(.alen(alen), .xlen(xlen), .depth(depth)) u_w_addr (
    .base(aw_q.addr), .size(aw_q.size), .burst(aw_q.burst), .len(aw_q.len),
    .beat(w_cnt_q), .idx(w_idx), .bad(w_bad)
  );

  // Write FSM: accept AW, sink len+1 beats, then hold B until taken.
  always_comb begin
    w_state_d    = w_state_q;
    aw_d         = aw_q;
    w_cnt_d      = w_cnt_q;
    w_err_d      = w_err_q;
    mem_we       = 1'b0;
    b_o          = '0;
    bus.aw_ready = 1'b0;
    bus.w_ready  = 1'b0;
    bus.b_valid  = 1'b0;
    case (w_state_q)
      W_IDLE: begin
        bus.aw_ready = rdy_en_q;
        if (rdy_en_q && bus.aw_valid) begin
          aw_d      = bus.aw;
          w_cnt_d   = '0;
          w_err_d   = 1'b0;
          w_state_d = W_DATA;
        end
      end
      W_DATA: begin
        bus.w_ready = 1'b1;
        if (bus.w_valid) begin
          mem_we  = rst_n && !w_bad;
          w_cnt_d = w_cnt_q + 8'd1;
          // A misplaced w.last only taints the response; the count decides the end.
          if (w_bad || (bus.w.last != (w_cnt_q == aw_q.len))) w_err_d = 1'b1;
          if (w_cnt_q == aw_q.len) w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        bus.b_valid = 1'b1;
        b_o.id      = aw_q.id;
        b_o.resp    = w_err_q ? SLVERR : OKAY;
        if (bus.b_ready) w_state_d = W_IDLE;
      end
      default: w_state_d = W_IDLE;
    endcase
  end

  assign bus.b = b_o;

  // Write-side state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      w_state_q <= W_IDLE;
      aw_q      <= '0;
      w_cnt_q   <= '0;
      w_err_q   <= 1'b0;
    end else begin
      w_state_q <= w_state_d;
      aw_q      <= aw_d;
      w_cnt_q   <= w_cnt_d;
      w_err_q   <= w_err_d;
    end
  end

  // Byte-strobed memory write; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we)
      for (int i = 0; i < NB; i++)
        if (bus.w.strb[i]) mem_q[w_idx][i*8 +: 8] <= bus.w.data[i*8 +: 8];
  end

  // In idle the calculator looks at the incoming AR so beat 0 is fetched on
  // the handshake; in a burst it looks one beat ahead of the one on the bus.
  always_comb begin
    if (r_state_q == R_IDLE) begin
      rd_addr  = bus.ar.addr;
      rd_size  = bus.ar.size;
      rd_burst = bus.ar.burst;
      rd_len   = bus.ar.len;
      rd_beat  = '0;
    end else begin
      rd_addr  = ar_q.addr;
      rd_size  = ar_q.size;
      rd_burst = ar_q.burst;
      rd_len   = ar_q.len;
      rd_beat  = r_cnt_q + 8'd1;
    end
  end

  axi5_burst_addr #(.alen(alen), .xlen(xlen), .depth(depth)) u_r_addr (
    .base(rd_addr), .size(rd_size), .burst(rd_burst), .len(rd_len),
    .beat(rd_beat), .idx(rd_idx), .bad(rd_bad)
  );

  // Fetch sees the memory before any same-edge write lands.
  assign rd_data = rd_bad ? '0 : mem_q[rd_idx];

  // Read FSM: the r register holds the presented beat until r_ready.
  always_comb begin
    r_state_d    = r_state_q;
    ar_d         = ar_q;
    r_cnt_d      = r_cnt_q;
    r_d          = r_q;
    bus.ar_ready = 1'b0;
    bus.r_valid  = 1'b0;
    case (r_state_q)
      R_IDLE: begin
        bus.ar_ready = rdy_en_q;
        if (rdy_en_q && bus.ar_valid) begin
          ar_d      = bus.ar;
          r_cnt_d   = '0;
          r_d.id    = bus.ar.id;
          r_d.data  = rd_data;
          r_d.resp  = rd_bad ? SLVERR : OKAY;
          r_d.last  = (bus.ar.len == 8'd0);
          r_state_d = R_DATA;
        end
      end
      R_DATA: begin
        bus.r_valid = 1'b1;
        if (bus.r_ready) begin
          if (r_q.last) begin
            r_d       = '0;
            r_state_d = R_IDLE;
          end else begin
            r_cnt_d  = rd_beat;
            r_d.id   = ar_q.id;
            r_d.data = rd_data;
            r_d.resp = rd_bad ? SLVERR : OKAY;
            r_d.last = (rd_beat == ar_q.len);
          end
        end
      end
      default: r_state_d = R_IDLE;
    endcase
  end

  assign bus.r = r_q;

  // Read-side state registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state_q <= R_IDLE;
      ar_q      <= '0;
      r_cnt_q   <= '0;
      r_q       <= '0;
    end else begin
      r_state_q <= r_state_d;
      ar_q      <= ar_d;
      r_cnt_q   <= r_cnt_d;
      r_q       <= r_d;
    end
  end

endmodule

// File: tb/tb_axi5_sram_slave.sv
// Directed bench for axi5_sram_slave: bursts, strobes, wrap, range errors,
// backpressure and mid-burst reset.
module tb_axi5_sram_slave;
  import axi5_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  logic [31:0] wd [16];
  logic [3:0]  ws [16];
  logic [31:0] ed [16];
  XRESP_t      er [16];

  always #5 clk = ~clk;

  axi5 #(.alen(32), .xlen(32), .ilen(2)) bus ();

  axi5_sram_slave #(.alen(32), .xlen(32), .ilen(2), .depth(256)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h exp %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic aw_send(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input AXBurst_t burst, input logic [1:0] id);
    int n = 0;
    bus.aw.addr = addr; bus.aw.len = len; bus.aw.size = size;
    bus.aw.burst = burst; bus.aw.id = id; bus.aw_valid = 1'b1;
    while (bus.aw_ready !== 1'b1 && n < 20) begin step(); n++; end
    if (n == 20) chk("aw_timeout", 64'd0, 64'd1);
    step();
    bus.aw_valid = 1'b0;
  endtask

  task automatic ar_send(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input AXBurst_t burst, input logic [1:0] id);
    int n = 0;
    bus.ar.addr = addr; bus.ar.len = len; bus.ar.size = size;
    bus.ar.burst = burst; bus.ar.id = id; bus.ar_valid = 1'b1;
    while (bus.ar_ready !== 1'b1 && n < 20) begin step(); n++; end
    if (n == 20) chk("ar_timeout", 64'd0, 64'd1);
    step();
    bus.ar_valid = 1'b0;
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
    int n = 0;
    bus.w.data = data; bus.w.strb = strb; bus.w.last = last; bus.w_valid = 1'b1;
    while (bus.w_ready !== 1'b1 && n < 20) begin step(); n++; end
    if (n == 20) chk("w_timeout", 64'd0, 64'd1);
    step();
    bus.w_valid = 1'b0;
  endtask

  // B must already be up the cycle after the last beat; aw_ready returns after.
  task automatic b_recv(input string tag, input logic [1:0] id, input XRESP_t resp);
    chk(tag, {bus.b_valid, bus.b.id, bus.b.resp}, {1'b1, id, resp});
    bus.b_ready = 1'b1;
    step();
    bus.b_ready = 1'b0;
    chk({tag, "_idle"}, {bus.aw_ready, bus.b_valid}, 2'b10);
  endtask

  task automatic wr_burst(input string tag, input logic [31:0] addr, input logic [7:0] len,
                          input AXBurst_t burst, input logic [1:0] id, input XRESP_t resp);
    aw_send(addr, len, 3'd2, burst, id);
    chk({tag, "_wrdy"}, {bus.aw_ready, bus.w_ready}, 2'b01);
    for (int i = 0; i <= int'(len); i++) w_send(wd[i], ws[i], 1'(i == int'(len)));
    b_recv(tag, id, resp);
  endtask

  task automatic wr1(input string tag, input logic [31:0] addr, input logic [31:0] data,
                     input logic [3:0] strb, input XRESP_t resp);
    wd[0] = data; ws[0] = strb;
    wr_burst(tag, addr, 8'd0, INCR, 2'd1, resp);
  endtask

  // r_ready held high: beats must appear back to back from the cycle after AR.
  task automatic rd_burst(input string tag, input logic [31:0] addr, input logic [7:0] len,
                          input logic [2:0] size, input AXBurst_t burst, input logic [1:0] id);
    ar_send(addr, len, size, burst, id);
    bus.r_ready = 1'b1;
    for (int i = 0; i <= int'(len); i++) begin
      chk($sformatf("%s_b%0d", tag, i),
          {bus.r_valid, bus.r.id, bus.r.resp, bus.r.last, bus.r.data},
          {1'b1, id, er[i], 1'(i == int'(len)), ed[i]});
      step();
    end
    bus.r_ready = 1'b0;
    chk({tag, "_end"}, {bus.ar_ready, bus.r_valid}, 2'b10);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "bench stopped by watchdog");
  end

  initial begin
    logic       rr [6];
    logic [31:0] rdat [6];
    logic       rlast [6];
    bus.aw = '0; bus.aw_valid = 1'b0; bus.w = '0; bus.w_valid = 1'b0; bus.b_ready = 1'b0;
    bus.ar = '0; bus.ar_valid = 1'b0; bus.r_ready = 1'b0;

    // reset state
    rst_n = 1'b0;
    repeat (3) step();
    chk("rst_vld", {bus.aw_ready, bus.w_ready, bus.b_valid, bus.ar_ready, bus.r_valid}, 5'b0);
    chk("rst_br", {bus.b, bus.r}, 64'd0);
    rst_n = 1'b1;
    step();
    chk("rel_rdy", {bus.aw_ready, bus.ar_ready, bus.w_ready}, 3'b110);

    // W before AW is stalled
    bus.w.data = 32'h5A5A5A5A; bus.w.strb = 4'hF; bus.w.last = 1'b1; bus.w_valid = 1'b1;
    step();
    chk("w_stall", bus.w_ready, 1'b0);
    bus.w_valid = 1'b0;

    // INCR write/read of four words
    wd[0] = 32'h11; wd[1] = 32'h22; wd[2] = 32'h33; wd[3] = 32'h44;
    for (int i = 0; i < 4; i++) ws[i] = 4'hF;
    wr_burst("incr_w", 32'h10, 8'd3, INCR, 2'd1, OKAY);
    ed[0] = 32'h11; ed[1] = 32'h22; ed[2] = 32'h33; ed[3] = 32'h44;
    for (int i = 0; i < 4; i++) er[i] = OKAY;
    rd_burst("incr_r", 32'h10, 8'd3, 3'd2, INCR, 2'd2);

    // byte strobes
    wr1("strb_w0", 32'h20, 32'hAABBCCDD, 4'hF, OKAY);
    wr1("strb_w1", 32'h20, 32'h00000011, 4'h1, OKAY);
    ed[0] = 32'hAABBCC11; er[0] = OKAY;
    rd_burst("strb_r", 32'h20, 8'd0, 3'd2, INCR, 2'd3);

    // WRAP read 0x38 len 3 -> 0x38,0x3C,0x30,0x34
    wd[0] = 32'hA0; wd[1] = 32'hA1; wd[2] = 32'hA2; wd[3] = 32'hA3;
    wr_burst("wrap_fill", 32'h30, 8'd3, INCR, 2'd0, OKAY);
    ed[0] = 32'hA2; ed[1] = 32'hA3; ed[2] = 32'hA0; ed[3] = 32'hA1;
    for (int i = 0; i < 4; i++) er[i] = OKAY;
    rd_burst("wrap_r", 32'h38, 8'd3, 3'd2, WRAP, 2'd1);
    for (int i = 0; i < 3; i++) begin ed[i] = 32'h0; er[i] = SLVERR; end
    rd_burst("wrap_bad", 32'h38, 8'd2, 3'd2, WRAP, 2'd2);

    // out-of-range write must not alias onto word 0
    wr1("oor_w0", 32'h0, 32'h12345678, 4'hF, OKAY);
    wr1("oor_w", 32'h400, 32'h0000DEAD, 4'hF, SLVERR);
    ed[0] = 32'h12345678; er[0] = OKAY;
    rd_burst("oor_chk", 32'h0, 8'd0, 3'd2, INCR, 2'd0);
    wr1("top_w", 32'h3FC, 32'hCAFEF00D, 4'hF, OKAY);
    ed[0] = 32'hCAFEF00D; er[0] = OKAY; ed[1] = 32'h0; er[1] = SLVERR;
    rd_burst("top_r", 32'h3FC, 8'd1, 3'd2, INCR, 2'd3);

    // FIXED burst lands both beats on one word
    wd[0] = 32'h1; wd[1] = 32'h2; ws[0] = 4'hF; ws[1] = 4'hF;
    wr_burst("fix_w", 32'h50, 8'd1, FIXED, 2'd2, OKAY);
    ed[0] = 32'h2; er[0] = OKAY;
    rd_burst("fix_r", 32'h50, 8'd0, 3'd2, INCR, 2'd2);
    // oversize beat
    ed[0] = 32'h0; er[0] = SLVERR;
    rd_burst("size_bad", 32'h50, 8'd0, 3'd3, INCR, 2'd1);

    // w.last early: burst still runs to len, response SLVERR, data kept
    aw_send(32'h60, 8'd1, 3'd2, INCR, 2'd3);
    w_send(32'h5, 4'hF, 1'b1);
    w_send(32'h6, 4'hF, 1'b1);
    b_recv("last_bad", 2'd3, SLVERR);
    ed[0] = 32'h5; ed[1] = 32'h6; er[0] = OKAY; er[1] = OKAY;
    rd_burst("last_rd", 32'h60, 8'd1, 3'd2, INCR, 2'd0);

    // R backpressure: r_ready 1,0,0,1,1,1
    rr[0] = 1; rr[1] = 0; rr[2] = 0; rr[3] = 1; rr[4] = 1; rr[5] = 1;
    rdat[0] = 32'h11; rdat[1] = 32'h22; rdat[2] = 32'h22; rdat[3] = 32'h22;
    rdat[4] = 32'h33; rdat[5] = 32'h44;
    rlast[0] = 0; rlast[1] = 0; rlast[2] = 0; rlast[3] = 0; rlast[4] = 0; rlast[5] = 1;
    ar_send(32'h10, 8'd3, 3'd2, INCR, 2'd1);
    for (int c = 0; c < 6; c++) begin
      bus.r_ready = rr[c];
      chk($sformatf("bp_r%0d", c), {bus.r_valid, bus.r.last, bus.r.data},
          {1'b1, rlast[c], rdat[c]});
      step();
    end
    bus.r_ready = 1'b0;
    chk("bp_r_end", {bus.ar_ready, bus.r_valid}, 2'b10);

    // B backpressure
    aw_send(32'h24, 8'd0, 3'd2, INCR, 2'd2);
    w_send(32'h99, 4'hF, 1'b1);
    for (int c = 0; c < 5; c++) begin
      chk($sformatf("bp_b%0d", c), {bus.b_valid, bus.aw_ready}, 2'b10);
      step();
    end
    b_recv("bp_b", 2'd2, OKAY);

    // reset in the middle of a len-7 write
    aw_send(32'h40, 8'd7, 3'd2, INCR, 2'd2);
    for (int i = 0; i < 3; i++) w_send(32'h100 + i, 4'hF, 1'b0);
    rst_n = 1'b0;
    step();
    chk("mid_rst", {bus.aw_ready, bus.w_ready, bus.b_valid, bus.ar_ready, bus.r_valid}, 5'b0);
    rst_n = 1'b1;
    step();
    chk("mid_rel", {bus.aw_ready, bus.ar_ready, bus.w_ready, bus.b_valid}, 4'b1100);
    wr1("post_rst_w", 32'h40, 32'h77, 4'hF, OKAY);
    ed[0] = 32'h77; er[0] = OKAY;
    rd_burst("post_rst_r", 32'h40, 8'd0, 3'd2, INCR, 2'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
